// File: rtl/sequence_controller.sv
// Simon round sequencer: grows the colour sequence, replays it on one-hot LEDs, then waits for the verdict.
// Optional macro SEQ_SPEEDUP_EN shortens the ON time as the sequence gets longer.
module sequence_controller #(
    parameter int MAX_LEN    = 32,
    parameter int ON_CYCLES  = 50,
    parameter int OFF_CYCLES = 25
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_start,
    input  logic                       i_gen_done,
    input  logic [2:0]                 i_gen_value,
    input  logic                       i_round_ok,
    input  logic                       i_round_fail,
    input  logic [$clog2(MAX_LEN)-1:0] i_rd_idx,
    output logic                       o_gen_trigger,
    output logic [3:0]                 o_led,
    output logic                       o_playing,
    output logic                       o_seq_ready,
    output logic [$clog2(MAX_LEN):0]   o_seq_len,
    output logic [2:0]                 o_rd_value,
    output logic                       o_win
);
    localparam int IDX_W = $clog2(MAX_LEN);
    localparam int LEN_W = IDX_W + 1;
    localparam int MAX_C = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int CNT_W = $clog2(MAX_C + 1);

    localparam logic [2:0] S_IDLE        = 3'd0;
    localparam logic [2:0] S_REQ         = 3'd1;
    localparam logic [2:0] S_WAIT_GEN    = 3'd2;
    localparam logic [2:0] S_SHOW_ON     = 3'd3;
    localparam logic [2:0] S_SHOW_OFF    = 3'd4;
    localparam logic [2:0] S_WAIT_PLAYER = 3'd5;
    localparam logic [2:0] S_DONE        = 3'd6;

    logic [2:0]       state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [IDX_W-1:0] play_q, play_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             win_q, win_d;
    logic             wr_en;
    logic [2:0]       seq_q [MAX_LEN];
    logic [CNT_W-1:0] on_load;
    logic             gen_legal;

    assign gen_legal = (i_gen_value >= 3'd1) && (i_gen_value <= 3'd4);

`ifdef SEQ_SPEEDUP_EN
    localparam int ON_MIN = (ON_CYCLES / 4 > 0) ? ON_CYCLES / 4 : 1;
    logic [31:0] on_shift;

    // Uses the length the sequence will have while it is being shown.
    always_comb begin
        on_shift = 32'(ON_CYCLES) >> (len_d >> 3);
        if (on_shift < 32'(ON_MIN)) on_shift = 32'(ON_MIN);
        on_load = CNT_W'(on_shift - 32'd1);
    end
`else
    assign on_load = CNT_W'(ON_CYCLES - 1);
`endif

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        play_d  = play_q;
        cnt_d   = cnt_q;
        win_d   = win_q;
        wr_en   = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (i_start) begin
                    len_d   = '0;
                    win_d   = 1'b0;
                    state_d = S_REQ;
                end
            end
            S_REQ: state_d = S_WAIT_GEN;
            S_WAIT_GEN: begin
                if (i_gen_done) begin
                    if (gen_legal && (len_q < LEN_W'(MAX_LEN))) begin
                        wr_en   = 1'b1;
                        len_d   = len_q + LEN_W'(1);
                        play_d  = '0;
                        cnt_d   = on_load;
                        state_d = S_SHOW_ON;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_SHOW_ON: begin
                if (cnt_q == '0) begin
                    cnt_d   = CNT_W'(OFF_CYCLES - 1);
                    state_d = S_SHOW_OFF;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_SHOW_OFF: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (LEN_W'(play_q) == len_q - LEN_W'(1)) begin
                    state_d = S_WAIT_PLAYER;
                end else begin
                    play_d  = play_q + IDX_W'(1);
                    cnt_d   = on_load;
                    state_d = S_SHOW_ON;
                end
            end
            S_WAIT_PLAYER: begin
                if (i_round_fail) begin
                    win_d   = 1'b0;
                    state_d = S_DONE;
                end else if (i_round_ok) begin
                    if (len_q == LEN_W'(MAX_LEN)) begin
                        win_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            play_q  <= '0;
            cnt_q   <= '0;
            win_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            play_q  <= play_d;
            cnt_q   <= cnt_d;
            win_q   <= win_d;
        end
    end

    // Storage needs no reset: only entries below len_q are ever observed.
    always_ff @(posedge i_clk) begin
        if (wr_en) seq_q[len_q[IDX_W-1:0]] <= i_gen_value;
    end

    always_comb begin
        o_led = 4'b0000;
        if (state_q == S_SHOW_ON) begin
            case (seq_q[play_q])
                3'd1:    o_led = 4'b0001;
                3'd2:    o_led = 4'b0010;
                3'd3:    o_led = 4'b0100;
                3'd4:    o_led = 4'b1000;
                default: o_led = 4'b0000;
            endcase
        end
    end

    assign o_gen_trigger = (state_q == S_REQ);
    assign o_playing     = (state_q == S_SHOW_ON) || (state_q == S_SHOW_OFF);
    assign o_seq_ready   = (state_q == S_WAIT_PLAYER);
    assign o_seq_len     = len_q;
    assign o_win         = win_q;
    assign o_rd_value    = (LEN_W'(i_rd_idx) < len_q) ? seq_q[i_rd_idx] : 3'd0;
endmodule
